// File: rtl/page_table_unit.sv
// Page-table store and single shared walker serving 8B and 32B TLB miss requests.
// Define PTU_STATS_EN to build the saturating request/fault statistics counters.
module page_table_unit #(
    parameter int LOOKUP_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PAGE_8B_RQST,
    input  logic [5:0]  PAGE_8B_LOOKUP,
    output logic [11:0] PAGE_8B_RECV,
    output logic        PAGE_8B_COMPLETE,
    input  logic        PAGE_32B_RQST,
    input  logic [3:0]  PAGE_32B_LOOKUP,
    output logic [7:0]  PAGE_32B_RECV,
    output logic        PAGE_32B_COMPLETE,
    output logic        PAGE_FAULT,
    input  logic        PT_WR_EN,
    input  logic        PT_WR_SEL,
    input  logic [5:0]  PT_WR_ADDR,
    input  logic [6:0]  PT_WR_DATA,
    output logic [15:0] PT_REQ_CNT,
    output logic [15:0] PT_FAULT_CNT
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(LOOKUP_LAT - 2);

    logic [63:0] valid8_q;
    logic [5:0]  ppn8_q [64];
    logic [15:0] valid32_q;
    logic [3:0]  ppn32_q [16];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic [5:0]  vpn_q, vpn_d;
    logic        pend8_q, pend8_d, pend32_q, pend32_d;
    logic [5:0]  pvpn8_q, pvpn8_d;
    logic [3:0]  pvpn32_q, pvpn32_d;
    logic [11:0] recv8_q, recv8_d;
    logic [7:0]  recv32_q, recv32_d;
    logic        cmp8_q, cmp8_d, cmp32_q, cmp32_d, fault_q, fault_d;
    logic        busy_s, acc8_s, acc32_s;

    // Valid bits are cleared by reset; 32B writes alias on ADDR[3:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            valid8_q  <= 64'd0;
            valid32_q <= 16'd0;
        end else if (PT_WR_EN) begin
            if (PT_WR_SEL) valid32_q[PT_WR_ADDR[3:0]] <= PT_WR_DATA[6];
            else           valid8_q[PT_WR_ADDR]       <= PT_WR_DATA[6];
        end
    end

    // PPN storage carries no reset; VALID gates every use of it.
    always_ff @(posedge clk) begin
        if (PT_WR_EN && PT_WR_SEL)  ppn32_q[PT_WR_ADDR[3:0]] <= PT_WR_DATA[3:0];
        if (PT_WR_EN && !PT_WR_SEL) ppn8_q[PT_WR_ADDR]       <= PT_WR_DATA[5:0];
    end

    // A request is dropped while its table already has one queued or walking.
    always_comb begin
        busy_s  = (state_q != ST_IDLE);
        acc8_s  = PAGE_8B_RQST  & ~pend8_q  & ~(busy_s & ~sel_q);
        acc32_s = PAGE_32B_RQST & ~pend32_q & ~(busy_s & sel_q);
    end

    // Walker next state: arbitration, latency countdown, table read and response.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        vpn_d    = vpn_q;
        pend8_d  = pend8_q | acc8_s;
        pend32_d = pend32_q | acc32_s;
        pvpn8_d  = acc8_s  ? PAGE_8B_LOOKUP  : pvpn8_q;
        pvpn32_d = acc32_s ? PAGE_32B_LOOKUP : pvpn32_q;
        recv8_d  = recv8_q;
        recv32_d = recv32_q;
        cmp8_d   = 1'b0;
        cmp32_d  = 1'b0;
        fault_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // An idle walker starts a fresh request in its arrival cycle.
                if (pend8_q || acc8_s) begin
                    state_d = ST_WALK;
                    cnt_d   = CNT_LOAD;
                    sel_d   = 1'b0;
                    vpn_d   = pend8_q ? pvpn8_q : PAGE_8B_LOOKUP;
                    pend8_d = 1'b0;
                end else if (pend32_q || acc32_s) begin
                    state_d  = ST_WALK;
                    cnt_d    = CNT_LOAD;
                    sel_d    = 1'b1;
                    vpn_d    = {2'b00, (pend32_q ? pvpn32_q : PAGE_32B_LOOKUP)};
                    pend32_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WALK: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (sel_q) begin
                        cmp32_d  = 1'b1;
                        fault_d  = ~valid32_q[vpn_q[3:0]];
                        recv32_d = {vpn_q[3:0], (valid32_q[vpn_q[3:0]] ? ppn32_q[vpn_q[3:0]] : 4'd0)};
                    end else begin
                        cmp8_d  = 1'b1;
                        fault_d = ~valid8_q[vpn_q];
                        recv8_d = {vpn_q, (valid8_q[vpn_q] ? ppn8_q[vpn_q] : 6'd0)};
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Walker and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            sel_q    <= 1'b0;
            vpn_q    <= 6'd0;
            pend8_q  <= 1'b0;
            pend32_q <= 1'b0;
            pvpn8_q  <= 6'd0;
            pvpn32_q <= 4'd0;
            recv8_q  <= 12'd0;
            recv32_q <= 8'd0;
            cmp8_q   <= 1'b0;
            cmp32_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            vpn_q    <= vpn_d;
            pend8_q  <= pend8_d;
            pend32_q <= pend32_d;
            pvpn8_q  <= pvpn8_d;
            pvpn32_q <= pvpn32_d;
            recv8_q  <= recv8_d;
            recv32_q <= recv32_d;
            cmp8_q   <= cmp8_d;
            cmp32_q  <= cmp32_d;
            fault_q  <= fault_d;
        end
    end

    assign PAGE_8B_RECV      = recv8_q;
    assign PAGE_32B_RECV     = recv32_q;
    assign PAGE_8B_COMPLETE  = cmp8_q;
    assign PAGE_32B_COMPLETE = cmp32_q;
    assign PAGE_FAULT        = fault_q;

`ifdef PTU_STATS_EN
    logic [15:0] req_cnt_q, fault_cnt_q;
    logic [16:0] req_sum_s, fault_sum_s;

    // Both tables may accept in the same cycle, so requests can add two.
    always_comb begin
        req_sum_s   = {1'b0, req_cnt_q} + {16'd0, acc8_s} + {16'd0, acc32_s};
        fault_sum_s = {1'b0, fault_cnt_q} + {16'd0, fault_d};
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_cnt_q   <= 16'd0;
            fault_cnt_q <= 16'd0;
        end else begin
            req_cnt_q   <= req_sum_s[16]   ? 16'hFFFF : req_sum_s[15:0];
            fault_cnt_q <= fault_sum_s[16] ? 16'hFFFF : fault_sum_s[15:0];
        end
    end

    assign PT_REQ_CNT   = req_cnt_q;
    assign PT_FAULT_CNT = fault_cnt_q;
`else
    assign PT_REQ_CNT   = 16'h0000;
    assign PT_FAULT_CNT = 16'h0000;
`endif
endmodule
